ro_capture_ctrl: RTL
====================

Name: ro_capture_ctrl

Overview:
- Sequences one ring-oscillator power-trace capture: arms the RO counter, times fixed sampling windows, latches each count and issues one cache-line write per sample to the DMA write path.
- Sits between the MMIO register block (go, rsa_go, wr_addr, num_samples, collect_cycles, done) and the RO counter / DMA write channel.
- Optionally launches the RSA victim in lockstep with the first sampling window.

Parameters:
- ADDR_WIDTH, 64, bits in DMA byte address.
- SIZE_WIDTH, 32, bits in num_samples and collect_cycles.
- COUNT_WIDTH, 32, bits in RO count.
- LINE_WIDTH, 512, DMA write data width (one cache line).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- go  in  1  single-cycle start pulse (capture only)
- rsa_go  in  1  single-cycle start pulse (capture plus RSA launch)
- wr_addr  in  ADDR_WIDTH  base byte address of output buffer, 64-byte aligned
- num_samples  in  SIZE_WIDTH  samples (cache lines) to write
- collect_cycles  in  SIZE_WIDTH  clocks per sampling window
- ro_count  in  COUNT_WIDTH  running RO edge count
- ro_clear  out  1  clears RO counter
- switcher_en  out  1  enables RO counting
- rsa_start  out  1  single-cycle RSA launch pulse
- dma_wr_valid  out  1  write request valid
- dma_wr_ready  in  1  write channel accepts
- dma_wr_addr  out  ADDR_WIDTH  byte address of current line
- dma_wr_data  out  LINE_WIDTH  line payload
- busy  out  1  capture in progress
- done  out  1  capture complete (sticky)

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0.
- Start: in IDLE or DONE, go or rsa_go = 1 starts a capture.
  - Latch wr_addr, num_samples and collect_cycles; capture uses only the latched copies.
  - Clear done; record an rsa flag when rsa_go = 1; go to ARM.
- Busy filtering: go and rsa_go are ignored while busy = 1 (states ARM, COLLECT, WRITE).
- Zero samples: num_samples = 0 at start -> next state DONE directly.
  - done asserts 1 cycle after the go pulse.
  - No writes, no rsa_start, no ro_clear.
- Zero window: collect_cycles = 0 is treated as 1.
- ARM (1 cycle):
  - ro_clear = 1; window counter := 0.
  - rsa_start = 1 on this cycle only when the rsa flag is set and sample index = 0.
  - Then go to COLLECT.
- COLLECT:
  - switcher_en = 1; window counter increments each cycle.
  - On the cycle the counter reaches collect_cycles-1: latch ro_count into sample register (value that cycle), then go to WRITE.
  - switcher_en drops to 0 the following cycle.
- WRITE:
  - dma_wr_valid = 1.
  - dma_wr_addr = base + 64*sample_index (ADDR_WIDTH arithmetic, wraps modulo 2^ADDR_WIDTH).
  - dma_wr_data = {zero pad, sample_index[31:0], latched count}; count occupies bits [COUNT_WIDTH-1:0], index bits [63:32].
  - valid, addr and data held stable until dma_wr_ready = 1.
  - On the accept cycle, sample_index increments. If new index == num_samples -> DONE, else -> ARM.
  - Valid deasserts the cycle after accept.
- DONE:
  - done = 1, busy = 0; done is held until the next accepted go or rsa_go.
  - Restart from DONE clears done on the cycle after the pulse.
- busy = 1 in ARM, COLLECT and WRITE only.
- Per-sample period with ready tied high: 1 (ARM) + collect_cycles (COLLECT) + 1 (WRITE) cycles.
- Simultaneous go and rsa_go: treated as rsa_go.
- Reset mid-capture: immediately returns to IDLE with all outputs 0.
  - Any in-flight dma_wr_valid is dropped; done = 0.

Test Plan:
- Basic capture: go, wr_addr=0x1000, num_samples=3, collect_cycles=4, ready=1, ro_count = cycle counter.
  - Expect 3 writes at 0x1000, 0x1040, 0x1080 with index fields 0, 1, 2.
  - Expect write spacing of 6 cycles.
  - Expect done 1 cycle after the third accept.
- Zero samples: go, num_samples=0 -> done=1 next cycle; no dma_wr_valid, ro_clear or switcher_en.
- Backpressure: dma_wr_ready held 0 for 10 cycles during the first write.
  - Expect valid, addr and data stable throughout and switcher_en=0.
  - Expect the capture to resume after ready and finish with 2 writes for num_samples=2.
- RSA launch: rsa_go, num_samples=2.
  - Expect exactly one rsa_start pulse, coincident with the first ro_clear.
  - Expect no pulse on the second sample.
  - A go pulse during busy is ignored: sample count unchanged, done timing unchanged.
- Reset mid-capture: assert rst during the WRITE of sample 1 of 4.
  - Expect all outputs 0 immediately.
  - A subsequent go with num_samples=1, collect_cycles=0 yields one write after a 1-cycle window, then done.
- Restart from DONE: after a completed capture, go with wr_addr=0xFFFF_FFFF_FFFF_FFC0, num_samples=2.
  - Expect done cleared.
  - Expect writes at 0xFFFF_FFFF_FFFF_FFC0 then 0x0 (address wrap).

Source files
------------

// File: rtl/ro_capture_ctrl_if.sv
// DMA write channel between the RO capture controller and the cache-line write path.
// The controller drives valid/addr/data; the write path answers with ready.
interface ro_capture_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512
) ();
    logic                  dma_wr_valid;
    logic                  dma_wr_ready;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [LINE_WIDTH-1:0] dma_wr_data;

    modport master (
        output dma_wr_valid,
        output dma_wr_addr,
        output dma_wr_data,
        input  dma_wr_ready
    );

    modport slave (
        input  dma_wr_valid,
        input  dma_wr_addr,
        input  dma_wr_data,
        output dma_wr_ready
    );
endinterface

// File: rtl/ro_capture_ctrl.sv
// Sequences one ring-oscillator power-trace capture: arm, time a window, latch the
// RO count and write it out as one cache line per sample, optionally launching RSA.
module ro_capture_ctrl #(
    parameter int ADDR_WIDTH  = 64,
    parameter int SIZE_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32,
    parameter int LINE_WIDTH  = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   rsa_go,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [SIZE_WIDTH-1:0]  num_samples,
    input  logic [SIZE_WIDTH-1:0]  collect_cycles,
    input  logic [COUNT_WIDTH-1:0] ro_count,
    output logic                   ro_clear,
    output logic                   switcher_en,
    output logic                   rsa_start,
    output logic                   busy,
    output logic                   done,
    ro_capture_ctrl_if.master      dma
);

    typedef enum logic [2:0] {IDLE, ARM, COLLECT, WRITE, DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [SIZE_WIDTH-1:0]  num_q;
    logic [SIZE_WIDTH-1:0]  cc_q;
    logic [SIZE_WIDTH-1:0]  win_cnt;
    logic [SIZE_WIDTH-1:0]  sample_idx;
    logic [COUNT_WIDTH-1:0] sample_q;
    logic                   valid_q;
    logic [LINE_WIDTH-1:0]  line;

    // Address and payload derive from registers only, so they stay stable while valid waits for ready.
    assign dma.dma_wr_valid = valid_q;
    assign dma.dma_wr_addr  = base_q + (ADDR_WIDTH'(sample_idx) << 6);

    always_comb begin
        line                       = '0;
        line[COUNT_WIDTH-1:0]      = sample_q;
        line[COUNT_WIDTH +: 32]    = 32'(sample_idx);
    end

    assign dma.dma_wr_data = line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            cc_q        <= '0;
            win_cnt     <= '0;
            sample_idx  <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            ro_clear    <= 1'b0;
            switcher_en <= 1'b0;
            rsa_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ro_clear  <= 1'b0;
            rsa_start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go || rsa_go) begin
                        base_q     <= wr_addr;
                        num_q      <= num_samples;
                        cc_q       <= (collect_cycles == '0) ? SIZE_WIDTH'(1) : collect_cycles;
                        win_cnt    <= '0;
                        sample_idx <= '0;
                        if (num_samples == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ARM;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                            ro_clear  <= 1'b1;
                            rsa_start <= rsa_go;
                        end
                    end
                end
                ARM: begin
                    state       <= COLLECT;
                    switcher_en <= 1'b1;
                    win_cnt     <= '0;
                end
                COLLECT: begin
                    if (win_cnt == cc_q - SIZE_WIDTH'(1)) begin
                        state       <= WRITE;
                        sample_q    <= ro_count;
                        switcher_en <= 1'b0;
                        valid_q     <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt + SIZE_WIDTH'(1);
                    end
                end
                WRITE: begin
                    if (dma.dma_wr_ready) begin
                        valid_q    <= 1'b0;
                        sample_idx <= sample_idx + SIZE_WIDTH'(1);
                        if (sample_idx + SIZE_WIDTH'(1) == num_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= ARM;
                            ro_clear <= 1'b1;
                            win_cnt  <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
